// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_pkg : shared constants, arbiter state type and anode helper    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;
    localparam int DIGIT_W    = 4;

    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 8'hFF;
    localparam logic [DIGIT_W-1:0]    LAMP_DIGIT = 4'h8;

    typedef enum logic [0:0] {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } rr_state_t;

    // Active-low one-hot anode pattern; all dark when the digit is not lit.
    function automatic logic [NUM_DIGITS-1:0] anode_drive(
        input logic             lit,
        input logic [IDX_W-1:0] idx
    );
        logic [NUM_DIGITS-1:0] an;
        an      = AN_ALL_OFF;
        an[idx] = ~lit;
        return an;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_rr_arbiter2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter2 : two-way round-robin arbiter, same-cycle grants       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_arbiter2
    import seg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    rr_state_t ptr_q;
    rr_state_t ptr_d;

    always_comb begin
        gnt_a = req_a & (~req_b | (ptr_q == PRI_A));
        gnt_b = req_b & ~gnt_a;
        ptr_d = ptr_q;
        if (gnt_a) begin
            ptr_d = PRI_B;
        end else if (gnt_b) begin
            ptr_d = PRI_A;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= PRI_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_scan_ctrl : 8-digit buffer, write arbiter, scan and PWM drive  |
// | Optional lamp test: define SEG_SCAN_LAMP_TEST_EN                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seg_scan_ctrl #(
    parameter int DIV_LOG2   = 17,
    parameter int NUM_DIGITS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_req_a,
    input  logic [seg_pkg::IDX_W-1:0]   wr_idx_a,
    input  logic [seg_pkg::DIGIT_W-1:0] wr_data_a,
    output logic                        wr_ack_a,
    input  logic                        wr_req_b,
    input  logic [seg_pkg::IDX_W-1:0]   wr_idx_b,
    input  logic [seg_pkg::DIGIT_W-1:0] wr_data_b,
    output logic                        wr_ack_b,
    input  logic [NUM_DIGITS-1:0]       blank_mask,
    input  logic [NUM_DIGITS-1:0]       dp_mask,
    input  logic [3:0]                  bright,
`ifdef SEG_SCAN_LAMP_TEST_EN
    input  logic                        lamp_test,
`endif
    output logic [seg_pkg::IDX_W-1:0]   digit_sel,
    output logic [seg_pkg::DIGIT_W-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        dp
);

    import seg_pkg::*;

    logic [DIV_LOG2-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]      scan_q, scan_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [DIGIT_W-1:0]    val_q, val_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  dp_q, dp_d;
    logic                  ack_a_q, ack_a_d;
    logic                  ack_b_q, ack_b_d;
    logic [DIGIT_W-1:0]    dbuf_q [NUM_DIGITS];
    logic [DIGIT_W-1:0]    dbuf_d [NUM_DIGITS];

    logic [3:0] phase;
    logic       lit;
    logic       lamp;
    logic       arb_req_a;
    logic       arb_req_b;
    logic       gnt_a;
    logic       gnt_b;

`ifdef SEG_SCAN_LAMP_TEST_EN
    assign lamp = lamp_test;
`else
    assign lamp = 1'b0;
`endif

    // A requester still sees its own ack this cycle and drops req next edge,
    // so its request is ignored while its ack is high.
    assign arb_req_a = wr_req_a & ~ack_a_q;
    assign arb_req_b = wr_req_b & ~ack_b_q;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_a (arb_req_a),
        .req_b (arb_req_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    always_comb begin
        presc_d = presc_q + DIV_LOG2'(1);
        scan_d  = scan_q;
        if (&presc_q) begin
            scan_d = scan_q + IDX_W'(1);
        end

        phase = presc_q[DIV_LOG2-1 -: 4];
        lit   = lamp | ((phase <= bright) & ~blank_mask[scan_q]);

        // digit_sel is delayed with an/dp/digit_val so all four stay aligned.
        sel_d = scan_q;
        an_d  = anode_drive(lit, scan_q);
        dp_d  = lamp ? 1'b0 : ~(lit & dp_mask[scan_q]);
        val_d = lamp ? LAMP_DIGIT : dbuf_q[scan_q];

        ack_a_d = gnt_a;
        ack_b_d = gnt_b;
        dbuf_d  = dbuf_q;
        if (gnt_a) begin
            dbuf_d[wr_idx_a] = wr_data_a;
        end else if (gnt_b) begin
            dbuf_d[wr_idx_b] = wr_data_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
            scan_q  <= '0;
            sel_q   <= '0;
            val_q   <= '0;
            an_q    <= AN_ALL_OFF;
            dp_q    <= 1'b1;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dbuf_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            val_q   <= val_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            dbuf_q  <= dbuf_d;
        end
    end

    assign wr_ack_a  = ack_a_q;
    assign wr_ack_b  = ack_b_q;
    assign digit_sel = sel_q;
    assign digit_val = val_q;
    assign an        = an_q;
    assign dp        = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seg_scan_ctrl : directed bench with a time-based reference model|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_seg_scan_ctrl;

    localparam int D    = 5;
    localparam int SLOT = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_req_a, wr_req_b;
    logic [2:0] wr_idx_a, wr_idx_b;
    logic [3:0] wr_data_a, wr_data_b;
    logic       wr_ack_a, wr_ack_b;
    logic [7:0] blank_mask, dp_mask;
    logic [3:0] bright;
    logic [2:0] digit_sel;
    logic [3:0] digit_val;
    logic [7:0] an;
    logic       dp;
`ifdef SEG_SCAN_LAMP_TEST_EN
    logic       lamp_test = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIV_LOG2(D), .NUM_DIGITS(8)) dut (
`ifdef SEG_SCAN_LAMP_TEST_EN
        .lamp_test  (lamp_test),
`endif
        .clk        (clk),
        .rst        (rst),
        .wr_req_a   (wr_req_a),
        .wr_idx_a   (wr_idx_a),
        .wr_data_a  (wr_data_a),
        .wr_ack_a   (wr_ack_a),
        .wr_req_b   (wr_req_b),
        .wr_idx_b   (wr_idx_b),
        .wr_data_b  (wr_data_b),
        .wr_ack_b   (wr_ack_b),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .bright     (bright),
        .digit_sel  (digit_sel),
        .digit_val  (digit_val),
        .an         (an),
        .dp         (dp)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference model: outputs follow from elapsed cycles since reset release.
    int unsigned mt;
    logic [3:0]  mbuf [8];
    logic        mptr_b;
    logic        mvalid = 1'b0;
    logic [7:0]  exp_an;
    logic        exp_dp, exp_ack_a, exp_ack_b;
    logic [2:0]  exp_sel;
    logic [3:0]  exp_val;

    logic [2:0]  m_slot;
    int          m_phase;
    logic        m_lamp, m_lit, m_ga, m_gb, m_ea, m_eb;
    logic [7:0]  m_an;
    logic        m_dp;
    logic [3:0]  m_val;

    always_comb begin
`ifdef SEG_SCAN_LAMP_TEST_EN
        m_lamp = lamp_test;
`else
        m_lamp = 1'b0;
`endif
        m_slot  = 3'((mt / SLOT) % 8);
        m_phase = int'((mt % SLOT) / (SLOT / 16));
        m_lit   = m_lamp || ((m_phase <= int'(bright)) && !blank_mask[m_slot]);
        m_an    = 8'hFF;
        if (m_lit) m_an[m_slot] = 1'b0;
        m_dp    = m_lamp ? 1'b0 : !(m_lit && dp_mask[m_slot]);
        m_val   = m_lamp ? 4'h8 : mbuf[m_slot];
        m_ea    = wr_req_a && !exp_ack_a;
        m_eb    = wr_req_b && !exp_ack_b;
        m_ga    = m_ea && (!m_eb || !mptr_b);
        m_gb    = m_eb && !m_ga;
    end

    always @(posedge clk) begin
        if (!rst) begin
            mt        <= 0;
            mptr_b    <= 1'b0;
            mvalid    <= 1'b1;
            exp_an    <= 8'hFF;
            exp_dp    <= 1'b1;
            exp_sel   <= 3'd0;
            exp_val   <= 4'd0;
            exp_ack_a <= 1'b0;
            exp_ack_b <= 1'b0;
            for (int i = 0; i < 8; i++) mbuf[i] <= 4'd0;
        end else begin
            mt        <= mt + 1;
            exp_an    <= m_an;
            exp_dp    <= m_dp;
            exp_sel   <= m_slot;
            exp_val   <= m_val;
            exp_ack_a <= m_ga;
            exp_ack_b <= m_gb;
            if (m_ga) begin
                mbuf[wr_idx_a] <= wr_data_a;
                mptr_b         <= 1'b1;
            end else if (m_gb) begin
                mbuf[wr_idx_b] <= wr_data_b;
                mptr_b         <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("an",        32'(an),        32'(exp_an));
            chk("dp",        32'(dp),        32'(exp_dp));
            chk("digit_sel", 32'(digit_sel), 32'(exp_sel));
            chk("digit_val", 32'(digit_val), 32'(exp_val));
            chk("wr_ack_a",  32'(wr_ack_a),  32'(exp_ack_a));
            chk("wr_ack_b",  32'(wr_ack_b),  32'(exp_ack_b));
            chk("ack_overlap", 32'(wr_ack_a & wr_ack_b), 32'd0);
        end
    end

    task automatic wait_sel(input logic [2:0] s, input int lim);
        int n = 0;
        while (digit_sel != s && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait_sel", 32'(digit_sel), 32'(s));
    endtask

    initial begin
        logic [7:0] want_an;
        logic [7:0] one = 8'h01;
        int         cnt;
        logic       an2_low;

        rst = 1'b0;
        wr_req_a = 1'b0; wr_idx_a = '0; wr_data_a = '0;
        wr_req_b = 1'b0; wr_idx_b = '0; wr_data_b = '0;
        blank_mask = 8'h00; dp_mask = 8'h00; bright = 4'd15;

        // Reset release: anode walks one digit per 32 cycles.
        repeat (3) @(negedge clk);
        chk("reset_an", 32'(an), 32'hFF);
        chk("reset_dp", 32'(dp), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("first_an", 32'(an), 32'hFE);
        chk("first_val", 32'(digit_val), 32'd0);
        for (int s = 1; s <= 8; s++) begin
            repeat (SLOT) @(negedge clk);
            want_an = ~(one << (s % 8));
            chk("scan_an", 32'(an), 32'(want_an));
        end

        // Single requester A.
        dp_mask = 8'h81;
        wr_req_a = 1'b1; wr_idx_a = 3'd3; wr_data_a = 4'd9;
        @(negedge clk);
        chk("a_ack", 32'(wr_ack_a), 32'd1);
        chk("a_no_b_ack", 32'(wr_ack_b), 32'd0);
        wr_req_a = 1'b0;
        repeat (2) @(negedge clk);
        wait_sel(3'd3, 300);
        chk("a_val", 32'(digit_val), 32'd9);

        // Both requesters from reset, same index.
        rst = 1'b0;
        wr_req_a = 1'b1; wr_idx_a = 3'd0; wr_data_a = 4'd1;
        wr_req_b = 1'b1; wr_idx_b = 3'd0; wr_data_b = 4'd2;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("both_ack_a", 32'(wr_ack_a), 32'd1);
        chk("both_ack_b0", 32'(wr_ack_b), 32'd0);
        wr_req_a = 1'b0;
        @(negedge clk);
        chk("both_ack_a0", 32'(wr_ack_a), 32'd0);
        chk("both_ack_b", 32'(wr_ack_b), 32'd1);
        wr_req_b = 1'b0;
        wait_sel(3'd1, 300);
        wait_sel(3'd0, 300);
        chk("final_buf0", 32'(digit_val), 32'd2);

        // PWM duty and blanking.
        bright = 4'd3;
        repeat (2) @(negedge clk);
        cnt = 0;
        repeat (8 * SLOT) begin
            @(negedge clk);
            if (an != 8'hFF) cnt++;
        end
        chk("duty_b3", 32'(cnt), 32'd64);
        blank_mask = 8'h04;
        repeat (2) @(negedge clk);
        cnt = 0; an2_low = 1'b0;
        repeat (8 * SLOT) begin
            @(negedge clk);
            if (an != 8'hFF) cnt++;
            if (!an[2]) an2_low = 1'b1;
        end
        chk("duty_blank", 32'(cnt), 32'd56);
        chk("an2_dark", 32'(an2_low), 32'd0);

        // One-cycle reset mid-scan with a pending write.
        wr_req_a = 1'b1; wr_idx_a = 3'd5; wr_data_a = 4'd7;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_an", 32'(an), 32'hFF);
        chk("mid_rst_sel", 32'(digit_sel), 32'd0);
        chk("mid_rst_val", 32'(digit_val), 32'd0);
        chk("mid_rst_ack", 32'(wr_ack_a), 32'd0);
        rst = 1'b1; wr_req_a = 1'b0;
        wait_sel(3'd3, 300);
        chk("mid_rst_buf3", 32'(digit_val), 32'd0);
        wait_sel(3'd5, 300);
        chk("mid_rst_buf5", 32'(digit_val), 32'd0);

`ifdef SEG_SCAN_LAMP_TEST_EN
        lamp_test = 1'b1; bright = 4'd0; blank_mask = 8'hFF;
        repeat (2) @(negedge clk);
        cnt = 0;
        repeat (8 * SLOT) begin
            @(negedge clk);
            if (an != 8'hFF && digit_val == 4'h8 && dp == 1'b0) cnt++;
        end
        chk("lamp_full", 32'(cnt), 32'(8 * SLOT));
        lamp_test = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
